// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC result collector: FSM states and frame geometry.
package cordic_pkg;

    localparam int VAL_W       = 11;
    localparam int FRAME_BYTES = 3;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_CAP0 = 3'd2,
        ST_CAP1 = 3'd3,
        ST_SEND = 3'd4
    } state_e;

endpackage

// File: rtl/cordic_result_collector.sv
// Runs one CORDIC computation per request, reads both results via the core's
// select line and streams them as a 3-byte frame on a valid/ready interface.
module cordic_result_collector
    import cordic_pkg::*;
#(
    parameter int VAL_W_P = VAL_W,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    output logic               busy_o,
    output logic               core_rst_o,
    output logic               core_sel_o,
    input  logic               core_done_i,
    input  logic [VAL_W_P-1:0] core_val_i,
    output logic [7:0]         out_data_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               out_last_o,
    output logic               err_timeout_o
);

    localparam int         CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [1:0] LAST_IDX  = 2'(FRAME_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [VAL_W_P-1:0] r0_q, r0_d;
    logic [VAL_W_P-1:0] r1_q, r1_d;
    logic [1:0]         idx_q, idx_d;
    logic               err_q, err_d;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            r0_q       <= '0;
            r1_q       <= '0;
            idx_q      <= 2'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            r0_q       <= r0_d;
            r1_q       <= r1_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic; done takes priority over the timeout in WAIT.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        r0_d       = r0_q;
        r1_d       = r1_q;
        idx_d      = idx_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                    err_d      = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
                if (core_done_i) begin
                    state_d = ST_CAP0;
                end else if (wait_cnt_q == CNT_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_CAP0: begin
                r0_d    = core_val_i;
                state_d = ST_CAP1;
            end
            ST_CAP1: begin
                // Core output is combinational on select, so it is valid this cycle.
                r1_d    = core_val_i;
                idx_d   = 2'd0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore output decode from state and captured registers.
    always_comb begin
        busy_o      = 1'b1;
        core_rst_o  = 1'b0;
        core_sel_o  = 1'b0;
        out_valid_o = 1'b0;
        out_last_o  = 1'b0;
        out_data_o  = 8'h00;
        case (state_q)
            ST_IDLE: begin
                busy_o     = 1'b0;
                core_rst_o = 1'b1;
            end
            ST_WAIT: begin
                core_rst_o = 1'b0;
            end
            ST_CAP0: begin
                core_sel_o = 1'b0;
            end
            ST_CAP1: begin
                core_sel_o = 1'b1;
            end
            ST_SEND: begin
                out_valid_o = 1'b1;
                out_last_o  = (idx_q == LAST_IDX);
                case (idx_q)
                    2'd0:    out_data_o = r0_q[7:0];
                    2'd1:    out_data_o = {r1_q[4:0], r0_q[10:8]};
                    2'd2:    out_data_o = {2'b00, r1_q[10:5]};
                    default: out_data_o = 8'h00;
                endcase
            end
            default: begin
                busy_o     = 1'b0;
                core_rst_o = 1'b1;
            end
        endcase
    end

    assign err_timeout_o = err_q;

endmodule
